keypad_scan_ctrl: RTL and testbench

Sequencing controller for the 4x4 matrix keypad. It drives the one-hot row strobes and synchronizes the column inputs. It locks onto a single pressed key, debounces both press and release, and emits exactly one registered key event per physical press. A two-digit history (newest/previous) feeds the dual seven-segment display path.

---
 rtl/keypad_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotates one-hot row strobes, locks onto a single key,
// debounces press and release, and emits one registered event per press.
module keypad_scan_ctrl #(
  parameter int SCAN_CYCLES     = 65536,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] REL_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t          state, state_n;
  logic [3:0]      col_m, col_s;
  logic [1:0]      row_idx, row_idx_n;
  logic [3:0]      col_lat, col_lat_n;
  logic [SW-1:0]   scan_cnt, scan_cnt_n;
  logic [DW-1:0]   db_cnt, db_cnt_n;
  logic [3:0]      row_n, key_code_n, digit_new_n, digit_old_n;
  logic            key_valid_n, key_held_n;
  logic            single_col, lat_hit;
  logic [3:0]      mapped;

  function automatic logic [3:0] map_code(input logic [1:0] r, input logic [3:0] c);
    logic [1:0] ci;
    ci = c[3] ? 2'd3 : c[2] ? 2'd2 : c[1] ? 2'd1 : 2'd0;
    // Codes run 1..F then wrap to 0 on the last key, so a 4-bit add suffices.
    return 4'({r, ci}) + 4'd1;
  endfunction

  assign single_col = (col_s != 4'd0) && ((col_s & (col_s - 4'd1)) == 4'd0);
  assign lat_hit    = (col_s & col_lat) != 4'd0;
  assign mapped     = map_code(row_idx, col_lat);

  always_comb begin
    state_n     = state;
    row_idx_n   = row_idx;
    col_lat_n   = col_lat;
    scan_cnt_n  = scan_cnt;
    db_cnt_n    = db_cnt;
    key_valid_n = 1'b0;
    key_code_n  = key_code;
    digit_new_n = digit_new;
    digit_old_n = digit_old;
    case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_n = '0;
          if (single_col) begin
            col_lat_n = col_s;
            db_cnt_n  = '0;
            state_n   = DEBOUNCE;
          end else begin
            row_idx_n = row_idx + 2'd1;
          end
        end else begin
          scan_cnt_n = scan_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s != col_lat) begin
          state_n    = SCAN;
          row_idx_n  = row_idx + 2'd1;
          scan_cnt_n = '0;
          db_cnt_n   = '0;
        end else if (db_cnt == DB_LAST) begin
          key_valid_n = 1'b1;
          key_code_n  = mapped;
          digit_old_n = digit_new;
          digit_new_n = mapped;
          db_cnt_n    = '0;
          state_n     = HELD;
        end else begin
          db_cnt_n = db_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!lat_hit) begin
          db_cnt_n = '0;
          state_n  = RELEASE;
        end
      end
      RELEASE: begin
        if (lat_hit) begin
          db_cnt_n = '0;
          state_n  = HELD;
        end else if (db_cnt == REL_LAST) begin
          state_n    = SCAN;
          row_idx_n  = row_idx + 2'd1;
          scan_cnt_n = '0;
          db_cnt_n   = '0;
        end else begin
          db_cnt_n = db_cnt + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
    key_held_n = (state_n == HELD) || (state_n == RELEASE);
    row_n      = 4'b0001 << row_idx_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_m     <= '0;
      col_s     <= '0;
      state     <= SCAN;
      row_idx   <= '0;
      row       <= 4'b0001;
      col_lat   <= '0;
      scan_cnt  <= '0;
      db_cnt    <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
      digit_new <= '0;
      digit_old <= '0;
    end else begin
      col_m     <= col;
      col_s     <= col_m;
      state     <= state_n;
      row_idx   <= row_idx_n;
      row       <= row_n;
      col_lat   <= col_lat_n;
      scan_cnt  <= scan_cnt_n;
      db_cnt    <= db_cnt_n;
      key_valid <= key_valid_n;
      key_code  <= key_code_n;
      key_held  <= key_held_n;
      digit_new <= digit_new_n;
      digit_old <= digit_old_n;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical key matrix model drives col from row,
// and a digit-history model predicts every accepted key.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  col, row, key_code, digit_new, digit_old;
  logic        key_valid, key_held;
  logic [15:0] pressed;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  logic prev_kv = 1'b0;
  int m_new = 0, m_old = 0, m_code = 0;

  keypad_scan_ctrl #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .key_valid(key_valid),
    .key_code(key_code), .key_held(key_held), .digit_new(digit_new), .digit_old(digit_old)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row line onto its column line.
  always_comb begin
    col = 4'd0;
    for (int r = 0; r < 4; r++)
      if (row[r]) col = col | pressed[r*4 +: 4];
  end

  always @(negedge clk) begin
    if (key_valid) begin
      pulses++;
      n_checks++;
      if (prev_kv) begin
        n_fail++;
        $display("FAIL kv_single_cycle: key_valid high on consecutive cycles");
      end
    end
    prev_kv = key_valid;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int code_of(input int r, input int c);
    return (r * 4 + c + 1) % 16;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_row_enter(input logic [3:0] target, output bit ok);
    logic [3:0] prev;
    ok = 0;
    prev = row;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (row == target && prev != target) begin
        ok = 1;
        break;
      end
      prev = row;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if (row !== 4'b0001 || key_valid !== 1'b0 || key_held !== 1'b0 ||
        key_code !== 4'd0 || digit_new !== 4'd0 || digit_old !== 4'd0) begin
      n_fail++;
      $display("FAIL %s: row=%b kv=%b held=%b code=%h new=%h old=%h, required row=0001 others 0",
               tag, row, key_valid, key_held, key_code, digit_new, digit_old);
    end
  endtask

  // Press one key, wait for acceptance, check the event, hold, release, wait for idle.
  task automatic accept_key(input int r, input int c, input int hold, input string tag);
    int start, t;
    int exp_code;
    exp_code = code_of(r, c);
    start = pulses;
    pressed[r*4+c] = 1'b1;
    t = 0;
    while (pulses == start && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (pulses != start + 1) begin
      n_fail++;
      $display("FAIL %s_pulse: got %0d pulses, required 1", tag, pulses - start);
    end
    m_old = m_new;
    m_new = exp_code;
    m_code = exp_code;
    n_checks++;
    if (key_code !== 4'(m_code) || digit_new !== 4'(m_new) || digit_old !== 4'(m_old) || key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_event: code=%h new=%h old=%h held=%b, required code=%h new=%h old=%h held=1",
               tag, key_code, digit_new, digit_old, key_held, m_code, m_new, m_old);
    end
    cyc(hold);
    pressed = 16'd0;
    t = 0;
    while (key_held && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (key_held !== 1'b0 || pulses != start + 1) begin
      n_fail++;
      $display("FAIL %s_release: held=%b pulses=%0d, required held=0 pulses=1", tag, key_held, pulses - start);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    int bad;
    reset = 1'b0;
    pressed = 16'd0;
    cyc(3);
    check_outputs_zero("reset_state");
    reset = 1'b1;
    bad = 0;
    for (int k = 0; k < 24; k++) begin
      cyc(1);
      exp_row = 4'b0001 << (((k + 1) / 4) % 4);
      n_checks++;
      if (row !== exp_row) begin
        n_fail++;
        bad++;
        if (bad < 4) $display("FAIL scan_row[%0d]: row=%b, required %b", k, row, exp_row);
      end
    end
    n_checks++;
    if (pulses != 0 || key_code !== 4'd0 || digit_new !== 4'd0 || digit_old !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_outputs: pulses=%0d code=%h new=%h old=%h, required all 0",
               pulses, key_code, digit_new, digit_old);
    end
  endtask

  task automatic test_key5();
    int start, t;
    start = pulses;
    pressed[4] = 1'b1;
    t = 0;
    while (pulses == start && t < 200) begin
      @(negedge clk);
      t++;
    end
    cyc(20);
    m_old = m_new; m_new = 5; m_code = 5;
    n_checks++;
    if (pulses != start + 1 || key_code !== 4'd5 || digit_new !== 4'd5 || key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL key5_event: pulses=%0d code=%h new=%h held=%b, required 1 5 5 1",
               pulses - start, key_code, digit_new, key_held);
    end
    pressed = 16'd0;
    t = 0;
    while (key_held && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (key_held !== 1'b0 || t < 8 || t > 14) begin
      n_fail++;
      $display("FAIL key5_release_time: held=%b after %0d cycles, required drop in 8..14", key_held, t);
    end
  endtask

  task automatic test_short_press();
    bit ok;
    int start, t;
    logic [3:0] nxt;
    start = pulses;
    wait_row_enter(4'b0001, ok);
    pressed[0] = 1'b1;
    cyc(7);
    n_checks++;
    if (!ok || row !== 4'b0001) begin
      n_fail++;
      $display("FAIL short_freeze: ok=%0d row=%b, required row frozen at 0001", ok, row);
    end
    pressed = 16'd0;
    t = 0;
    while (row == 4'b0001 && t < 30) begin
      @(negedge clk);
      t++;
    end
    nxt = row;
    cyc(20);
    n_checks++;
    if (nxt !== 4'b0010 || pulses != start || key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL short_press: next row=%b pulses=%0d held=%b, required 0010 0 0",
               nxt, pulses - start, key_held);
    end
  endtask

  task automatic test_back_to_back();
    accept_key(0, 0, 10, "b2b_key1");
    accept_key(2, 1, 10, "b2b_keyA");
    n_checks++;
    if (digit_old !== 4'h1 || digit_new !== 4'hA || key_code !== 4'hA) begin
      n_fail++;
      $display("FAIL b2b_history: old=%h new=%h code=%h, required 1 A A", digit_old, digit_new, key_code);
    end
  endtask

  task automatic test_second_key_glitch();
    int start, t, held_low;
    start = pulses;
    pressed[4] = 1'b1;
    t = 0;
    while (pulses == start && t < 200) begin
      @(negedge clk);
      t++;
    end
    m_old = m_new; m_new = 5; m_code = 5;
    pressed[6] = 1'b1;
    held_low = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) pressed[4] = 1'b0;
      if (i == 13) pressed[4] = 1'b1;
      @(negedge clk);
      if (!key_held) held_low++;
    end
    n_checks++;
    if (held_low != 0 || pulses != start + 1 || digit_new !== 4'd5 || digit_old !== 4'(m_old)) begin
      n_fail++;
      $display("FAIL glitch_hold: held_low=%0d pulses=%0d new=%h old=%h, required 0 1 5 %h",
               held_low, pulses - start, digit_new, digit_old, m_old);
    end
    pressed = 16'd0;
    cyc(30);
    n_checks++;
    if (key_held !== 1'b0 || pulses != start + 1) begin
      n_fail++;
      $display("FAIL glitch_release: held=%b pulses=%0d, required 0 1", key_held, pulses - start);
    end
  endtask

  task automatic test_reset_and_multi();
    bit ok;
    int start, changes;
    logic [3:0] prev;
    start = pulses;
    wait_row_enter(4'b1000, ok);
    pressed[14] = 1'b1;
    cyc(6);
    n_checks++;
    if (!ok || row !== 4'b1000) begin
      n_fail++;
      $display("FAIL keyF_debounce: ok=%0d row=%b, required row frozen at 1000", ok, row);
    end
    reset = 1'b0;
    #1;
    check_outputs_zero("reset_mid_debounce");
    m_new = 0; m_old = 0; m_code = 0;
    cyc(2);
    pressed = 16'd0;
    cyc(1);
    reset = 1'b1;
    cyc(30);
    n_checks++;
    if (pulses != start || key_code !== 4'd0 || digit_new !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_no_event: pulses=%0d code=%h new=%h, required 0 0 0", pulses - start, key_code, digit_new);
    end
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    changes = 0;
    prev = row;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (row != prev) changes++;
      prev = row;
    end
    n_checks++;
    if (changes < 10 || pulses != start || key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_col: row changes=%0d pulses=%0d held=%b, required >=10 0 0",
               changes, pulses - start, key_held);
    end
    pressed = 16'd0;
    cyc(5);
  endtask

  task automatic test_random_keys();
    int r, c;
    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(3, 0));
      c = int'($urandom_range(3, 0));
      cyc(int'($urandom_range(20, 0)));
      accept_key(r, c, int'($urandom_range(30, 2)), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    reset = 1'b0;
    pressed = 16'd0;
    test_reset();
    test_key5();
    test_short_press();
    test_back_to_back();
    test_second_key_glitch();
    test_reset_and_multi();
    test_random_keys();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
